// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and func3 legality helper for the LSU sequencer.
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W = 6;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned F3_W_BITS  = 3;

  localparam logic [F3_W_BITS-1:0] F3_B  = 3'b000;
  localparam logic [F3_W_BITS-1:0] F3_H  = 3'b001;
  localparam logic [F3_W_BITS-1:0] F3_W  = 3'b010;
  localparam logic [F3_W_BITS-1:0] F3_BU = 3'b100;
  localparam logic [F3_W_BITS-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_e;

  // Stores allow B/H/W; loads additionally allow the unsigned B/H forms.
  function automatic logic f3_legal(input logic we, input logic [F3_W_BITS-1:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_req_check.sv
// Combinational legality and natural-alignment check of an incoming request.
module lsu_req_check
  import lsu_pkg::*;
(
  input  logic                 we_i,
  input  logic [F3_W_BITS-1:0] func3_i,
  input  logic [1:0]           addr_lo_i,
  output logic                 legal_c_o,
  output logic                 misaligned_c_o
);

  // Halfwords need an even address, words a 4-byte aligned one.
  always_comb begin
    legal_c_o      = f3_legal(we_i, func3_i);
    misaligned_c_o = 1'b0;
    case (func3_i[1:0])
      2'b01:   misaligned_c_o = addr_lo_i[0];
      2'b10:   misaligned_c_o = (addr_lo_i != 2'b00);
      default: misaligned_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store request sequencer: one access in flight, registered memory port and response.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [F3_W_BITS-1:0] req_func3,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_ena,
  output logic                 mem_we,
  output logic [F3_W_BITS-1:0] mem_func3,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_store_data,
  input  logic [DATA_W-1:0]    mem_load_data
);

  lsu_state_e             state_q, state_d;
  logic                   req_we_q, req_we_d;
  logic                   req_ready_d;
  logic                   rsp_valid_d;
  logic [DATA_W-1:0]      rsp_rdata_d;
  logic                   rsp_err_d;
  logic                   mem_ena_d;
  logic                   mem_we_d;
  logic [F3_W_BITS-1:0]   mem_func3_d;
  logic [ADDR_W-1:0]      mem_addr_d;
  logic [DATA_W-1:0]      mem_store_data_d;

  logic                   accept_c;
  logic                   legal_c;
  logic                   misaligned_c;
  logic                   req_ok_c;

  assign accept_c = req_valid && req_ready && (state_q == ST_IDLE);
  assign req_ok_c = legal_c && !misaligned_c;

  // Request decode, consulted only on the accept cycle.
  lsu_req_check u_req_check (
    .we_i           (req_we),
    .func3_i        (req_func3),
    .addr_lo_i      (req_addr[1:0]),
    .legal_c_o      (legal_c),
    .misaligned_c_o (misaligned_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = req_ok_c ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS:  state_d = req_we_q ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; memory fields change only on a legal accept.
  always_comb begin
    req_we_d         = req_we_q;
    mem_func3_d      = mem_func3;
    mem_addr_d       = mem_addr;
    mem_store_data_d = mem_store_data;
    rsp_rdata_d      = rsp_rdata;
    rsp_err_d        = rsp_err;

    if (accept_c) begin
      req_we_d = req_we;
      if (req_ok_c) begin
        mem_func3_d      = req_func3;
        mem_addr_d       = req_addr;
        mem_store_data_d = req_wdata;
      end else begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
      end
    end

    if (state_q == ST_ACCESS && req_we_q) begin
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
    end

    if (state_q == ST_CAPTURE) begin
      rsp_rdata_d = mem_load_data;
      rsp_err_d   = 1'b0;
    end

    mem_ena_d   = (state_d == ST_ACCESS);
    mem_we_d    = (state_d == ST_ACCESS) && req_we_d;
    rsp_valid_d = (state_d == ST_RESP);
    req_ready_d = (state_d == ST_IDLE);
  end

  // Output and request registers; reset clears every output at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_we_q       <= 1'b0;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      mem_ena        <= 1'b0;
      mem_we         <= 1'b0;
      mem_func3      <= '0;
      mem_addr       <= '0;
      mem_store_data <= '0;
    end else begin
      req_we_q       <= req_we_d;
      req_ready      <= req_ready_d;
      rsp_valid      <= rsp_valid_d;
      rsp_rdata      <= rsp_rdata_d;
      rsp_err        <= rsp_err_d;
      mem_ena        <= mem_ena_d;
      mem_we         <= mem_we_d;
      mem_func3      <= mem_func3_d;
      mem_addr       <= mem_addr_d;
      mem_store_data <= mem_store_data_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-write memory and 1-cycle registered read.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_ena;
  logic        mem_we;
  logic [2:0]  mem_func3;
  logic [5:0]  mem_addr;
  logic [31:0] mem_store_data;
  logic [31:0] mem_load_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_func3      (req_func3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_ena        (mem_ena),
    .mem_we         (mem_we),
    .mem_func3      (mem_func3),
    .mem_addr       (mem_addr),
    .mem_store_data (mem_store_data),
    .mem_load_data  (mem_load_data)
  );

  // Little-endian byte memory; read word registered, lanes extracted from the live addr/func3.
  logic [7:0]  mem [64];
  logic [31:0] rd_q;

  always @(posedge clk) begin
    if (mem_ena && mem_we) begin
      case (mem_func3[1:0])
        2'b00: mem[mem_addr] <= mem_store_data[7:0];
        2'b01: begin
          mem[mem_addr]        <= mem_store_data[7:0];
          mem[mem_addr + 6'd1] <= mem_store_data[15:8];
        end
        default: begin
          mem[{mem_addr[5:2], 2'b00}] <= mem_store_data[7:0];
          mem[{mem_addr[5:2], 2'b01}] <= mem_store_data[15:8];
          mem[{mem_addr[5:2], 2'b10}] <= mem_store_data[23:16];
          mem[{mem_addr[5:2], 2'b11}] <= mem_store_data[31:24];
        end
      endcase
    end
    if (mem_ena && !mem_we) begin
      rd_q <= {mem[{mem_addr[5:2], 2'b11}], mem[{mem_addr[5:2], 2'b10}],
               mem[{mem_addr[5:2], 2'b01}], mem[{mem_addr[5:2], 2'b00}]};
    end
  end

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  assign mem_load_data = extract(rd_q, mem_addr[1:0], mem_func3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; returns at the falling edge of cycle 1.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [5:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [5:0] a,
                           input logic [31:0] d);
    chk({tag, "_c0_ready"}, 32'(req_ready), 32'd1);
    issue(1'b1, f3, a, d);
    chk({tag, "_c1_ena"},  32'(mem_ena), 32'd1);
    chk({tag, "_c1_we"},   32'(mem_we), 32'd1);
    chk({tag, "_c1_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_c1_rspv"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_c2_ena"},   32'(mem_ena), 32'd0);
    chk({tag, "_c2_rspv"},  32'(rsp_valid), 32'd1);
    chk({tag, "_c2_err"},   32'(rsp_err), 32'd0);
    chk({tag, "_c2_rdata"}, rsp_rdata, 32'd0);
    @(negedge clk);
    chk({tag, "_c3_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_c3_rspv"},  32'(rsp_valid), 32'd0);
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [5:0] a,
                          input logic [31:0] exp);
    chk({tag, "_c0_ready"}, 32'(req_ready), 32'd1);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, "_c1_ena"},  32'(mem_ena), 32'd1);
    chk({tag, "_c1_we"},   32'(mem_we), 32'd0);
    chk({tag, "_c1_addr"}, 32'(mem_addr), 32'(a));
    @(negedge clk);
    chk({tag, "_c2_ena"},  32'(mem_ena), 32'd0);
    chk({tag, "_c2_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_c2_f3"},   32'(mem_func3), 32'(f3));
    chk({tag, "_c2_rspv"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_c3_rspv"},  32'(rsp_valid), 32'd1);
    chk({tag, "_c3_err"},   32'(rsp_err), 32'd0);
    chk({tag, "_c3_rdata"}, rsp_rdata, exp);
    if (rsp_ready) begin
      @(negedge clk);
      chk({tag, "_c4_ready"}, 32'(req_ready), 32'd1);
    end
  endtask

  task automatic run_err(input string tag, input logic we, input logic [2:0] f3,
                         input logic [5:0] a);
    chk({tag, "_c0_ready"}, 32'(req_ready), 32'd1);
    issue(we, f3, a, 32'hCAFEF00D);
    chk({tag, "_c1_rspv"},  32'(rsp_valid), 32'd1);
    chk({tag, "_c1_err"},   32'(rsp_err), 32'd1);
    chk({tag, "_c1_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_c1_ena"},   32'(mem_ena), 32'd0);
    @(negedge clk);
    chk({tag, "_c2_ena"},   32'(mem_ena), 32'd0);
    chk({tag, "_c2_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int gap;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_func3 = 3'b000;
    req_addr  = 6'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_ena",   32'(mem_ena), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Store then byte loads of its top byte.
    run_store("sw08", 3'b010, 6'h08, 32'hDEADBEEF);
    chk("sw08_c1_sdata_kept", mem_store_data, 32'hDEADBEEF);
    run_load("lb0b",  3'b000, 6'h0B, 32'hFFFFFFDE);
    run_load("lbu0b", 3'b100, 6'h0B, 32'h000000DE);

    // Illegal and misaligned requests.
    run_err("lh09",   1'b0, 3'b001, 6'h09);
    chk("lh09_addr_unchanged", 32'(mem_addr), 32'h0B);
    run_err("ld011",  1'b0, 3'b011, 6'h00);
    run_err("sbu_st", 1'b1, 3'b100, 6'h00);
    run_err("sw0a",   1'b1, 3'b010, 6'h0A);

    // Load with the response held off for five cycles.
    rsp_ready = 1'b0;
    run_load("lw08_stall", 3'b010, 6'h08, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rspv",  32'(rsp_valid), 32'd1);
      chk("stall_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("stall_err",   32'(rsp_err), 32'd0);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_done_rspv",  32'(rsp_valid), 32'd0);
    chk("stall_done_ready", 32'(req_ready), 32'd1);

    // Back-to-back halfword store then unsigned halfword load.
    run_store("sh06", 3'b001, 6'h06, 32'h00009ABC);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'b001;
    req_addr  = 6'h04;
    req_wdata = 32'hFFFF7123;
    @(negedge clk);
    req_we    = 1'b0;
    req_func3 = 3'b101;
    req_addr  = 6'h06;
    gap = 1;
    while (!req_ready && gap < 10) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_spacing", 32'(gap), 32'd3);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_lhu_c1_addr", 32'(mem_addr), 32'h06);
    repeat (2) @(negedge clk);
    chk("b2b_lhu_rspv",  32'(rsp_valid), 32'd1);
    chk("b2b_lhu_rdata", rsp_rdata, 32'h00009ABC);
    @(negedge clk);
    run_load("lw04", 3'b010, 6'h04, 32'h9ABC7123);

    // Reset in the ACCESS cycle of a byte store; store must not land.
    issue(1'b1, 3'b000, 6'h08, 32'h00000055);
    chk("abort_c1_ena", 32'(mem_ena), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_ena_now",   32'(mem_ena), 32'd0);
    chk("abort_we_now",    32'(mem_we), 32'd0);
    chk("abort_ready_now", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'b010;
    req_addr  = 6'h08;
    req_wdata = 32'h11111111;
    @(negedge clk);
    chk("abort_rst_ena", 32'(mem_ena), 32'd0);
    req_valid = 1'b0;
    rst       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_load("lw08_after_abort", 3'b010, 6'h08, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store request sequencer that sits between the core's load/store stage and the byte-write memory system. It accepts one RISC-V load or store per valid/ready handshake and checks func3 legality and natural alignment. It drives the memory system's ena/func3/addr/store_data port, holding address and func3 stable across the 1-cycle registered read latency so the receiver's lane extraction sees the correct address. It returns load data or a store acknowledge over a valid/ready response channel.

## Interface
- ADDR_W, 6: byte address width; matches the memory system address port.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE, low while rst is asserted.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RISC-V funct3 of the access.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present; reset 0.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors; reset 0.
- rsp_err  out  1  illegal func3 or misaligned access; reset 0.
- mem_ena  out  1  memory port enable; reset 0.
- mem_we  out  1  write qualifier; the memory top gates w_mask with it; reset 0.
- mem_func3  out  3  func3 to the memory system; reset 0.
- mem_addr  out  ADDR_W  byte address to the memory system; reset 0.
- mem_store_data  out  32  store data to the memory system; reset 0.
- mem_load_data  in  32  extended load data from the memory system; valid 1 cycle after an enabled read, given addr and func3 unchanged.

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: on req_valid && req_ready, register we, func3, addr, and wdata.
  - Legal, aligned access: go to ACCESS.
  - Otherwise: go to RESP with rsp_err=1 and rsp_rdata=0. No memory access occurs.
- Legal func3:
  - Stores: 000 (SB), 001 (SH), 010 (SW).
  - Loads: 000, 001, 010, 100 (LBU), 101 (LHU).
  - Anything else is an error.
- Misaligned access is an error:
  - halfword (x01) with addr[0]=1.
  - word (010) with addr[1:0]≠0.
- ACCESS: mem_ena=1, mem_we=req_we. mem_func3, mem_addr, and mem_store_data come from the registered request.
  - Store: the write commits at the end of this cycle; next state is RESP with rsp_err=0 and rsp_rdata=0.
  - Load: next state is CAPTURE.
- CAPTURE: mem_ena=0 and mem_we=0. mem_addr and mem_func3 are held unchanged. At the clock edge ending this cycle, rsp_rdata is loaded from mem_load_data, and the next state is RESP.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable. On rsp_ready, go to IDLE and clear rsp_valid.
- Outside ACCESS, mem_ena=0 and mem_we=0.
- mem_addr, mem_func3, and mem_store_data keep their last values in IDLE and RESP.
- No request is accepted while a response is outstanding; maximum one access in flight.

## Timing
- The accept edge is cycle 0.
- Store: ACCESS is cycle 1 and rsp_valid rises in cycle 2.
- Load: ACCESS is cycle 1, CAPTURE is cycle 2, and rsp_valid rises in cycle 3.
- Error: rsp_valid rises in cycle 1.
- Minimum request spacing:
  - 3 cycles for a store (rsp_ready held high).
  - 4 cycles for a load.
  - 2 cycles for an error.
- rsp_ready may be low for any number of cycles; all outputs hold their values while it is low.
- Reset mid-operation:
  - All state returns to IDLE and all outputs go to 0 immediately, without waiting for a clock edge.
  - A store whose ACCESS cycle sees rst asserted before its edge is not written.
  - An in-flight access produces no response.
- req_valid while rst is asserted is ignored.

## Structure
- lsu_pkg:
  - func3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum.
  - ADDR_W default.
- Sub-module lsu_req_check: combinational check of func3, addr, and we; outputs legal and misaligned flags. Instantiated once, in IDLE decode.
- The FSM and response registers live in lsu_mem_ctrl.

## Test plan
- SW addr 0x08 data 0xDEADBEEF -> mem_ena=1, mem_we=1 exactly in cycle 1; rsp_valid in cycle 2 with rsp_err=0 and rsp_rdata=0.
- After that store, LB addr 0x0B -> mem_addr=0x0B held in cycles 1-2; rsp_rdata=0xFFFFFFDE in cycle 3. LBU addr 0x0B -> 0x000000DE.
- LH addr 0x09 -> rsp_err=1 in cycle 1, mem_ena never asserted. func3=011 load -> rsp_err=1.
- LW with rsp_ready low for 5 cycles -> rsp_valid, rsp_rdata, and rsp_err stable; req_ready=0 throughout; IDLE the cycle after rsp_ready.
- rst asserted during a SB ACCESS cycle -> mem_ena drops immediately; a later LW of that address returns the old word; no rsp_valid for the aborted request.
- Back-to-back SH 0x04 then LHU 0x06 with rsp_ready=1 -> accept spacing of 3 cycles; load data equals the stored halfword zero-extended.
